// File: rtl/ram_port_arbiter.sv
// N-channel arbiter that time-multiplexes several bus masters onto one synchronous RAM port.
// Supports round-robin or fixed-priority arbitration and routes each read return to its issuing channel.
module ram_port_arbiter #(
    parameter int N_CH   = 2,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2,
    parameter int MODE   = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          wr,
    input  logic [N_CH*ADDR_W-1:0]   addr,
    input  logic [N_CH*DATA_W-1:0]   wdata,
    output logic [N_CH-1:0]          gnt,
    output logic [N_CH-1:0]          rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [ADDR_W-1:0]        mem_address,
    output logic                     mem_wren,
    output logic [DATA_W-1:0]        mem_data,
    input  logic [DATA_W-1:0]        mem_q
);

    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             any_gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             sel_wr;
    logic             lo_found, hi_found;
    logic [IDX_W-1:0] lo_idx, hi_idx;

    logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
    logic [IDX_W-1:0]  rd_ch_q [RD_LAT];
    logic [IDX_W-1:0]  rd_ch_d [RD_LAT];

    // Descending scan: the last hit is the lowest index, both overall and at/above ptr.
    always_comb begin
        lo_found = 1'b0;
        lo_idx   = '0;
        hi_found = 1'b0;
        hi_idx   = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
            end
            if (req[i] && (IDX_W'(i) >= ptr_q)) begin
                hi_found = 1'b1;
                hi_idx   = IDX_W'(i);
            end
        end
        any_gnt = lo_found && !reset;
        if (MODE == 1) begin
            gnt_idx = lo_idx;
        end else begin
            gnt_idx = hi_found ? hi_idx : lo_idx;
        end
    end

    always_comb begin
        gnt         = '0;
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        sel_wr      = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (any_gnt && (gnt_idx == IDX_W'(i))) begin
                gnt[i]      = 1'b1;
                mem_address = addr[i*ADDR_W +: ADDR_W];
                mem_data    = wdata[i*DATA_W +: DATA_W];
                sel_wr      = wr[i];
                mem_wren    = wr[i];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if ((MODE == 0) && any_gnt) begin
            ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Read-return pipeline: stage 0 is loaded on the grant edge, stage RD_LAT-1 lines up with mem_q.
    always_comb begin
        rd_vld_d[0] = any_gnt && !sel_wr;
        rd_ch_d[0]  = gnt_idx;
        for (int s = 1; s < RD_LAT; s++) begin
            rd_vld_d[s] = rd_vld_q[s-1];
            rd_ch_d[s]  = rd_ch_q[s-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q    <= '0;
            rd_vld_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    always_ff @(posedge clock) begin
        rd_ch_q <= rd_ch_d;
    end

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < N_CH; i++) begin
            rvalid[i] = !reset && rd_vld_q[RD_LAT-1] && (rd_ch_q[RD_LAT-1] == IDX_W'(i));
        end
    end

    assign rdata = mem_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: three instances (RR 2ch/lat2, fixed-priority 2ch/lat2, RR 3ch/lat3)
// each backed by a small behavioural synchronous RAM with matching read latency.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   cnt0, cnt1;

    logic        pl_we   = 1'b0;
    logic [7:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;

    // Instance A: round-robin, 2 channels, latency 2
    logic [1:0]  a_req = '0, a_wr = '0;
    logic [31:0] a_addr = '0, a_wdata = '0;
    logic [1:0]  a_gnt, a_rvalid;
    logic [15:0] a_rdata, a_maddr, a_mdata, a_mq;
    logic        a_mwren;

    // Instance B: fixed priority, 2 channels, latency 2
    logic [1:0]  b_req = '0, b_wr = '0;
    logic [31:0] b_addr = '0, b_wdata = '0;
    logic [1:0]  b_gnt, b_rvalid;
    logic [15:0] b_rdata, b_maddr, b_mdata;
    logic [15:0] b_mq = 16'h0000;
    logic        b_mwren;

    // Instance C: round-robin, 3 channels, latency 3
    logic [2:0]  c_req = '0, c_wr = '0;
    logic [47:0] c_addr = '0, c_wdata = '0;
    logic [2:0]  c_gnt, c_rvalid;
    logic [15:0] c_rdata, c_maddr, c_mdata, c_mq;
    logic        c_mwren;

    ram_port_arbiter #(.N_CH(2), .ADDR_W(16), .DATA_W(16), .RD_LAT(2), .MODE(0)) dut_a (
        .clock(clk), .reset(rst), .req(a_req), .wr(a_wr), .addr(a_addr), .wdata(a_wdata),
        .gnt(a_gnt), .rvalid(a_rvalid), .rdata(a_rdata), .mem_address(a_maddr),
        .mem_wren(a_mwren), .mem_data(a_mdata), .mem_q(a_mq)
    );

    ram_port_arbiter #(.N_CH(2), .ADDR_W(16), .DATA_W(16), .RD_LAT(2), .MODE(1)) dut_b (
        .clock(clk), .reset(rst), .req(b_req), .wr(b_wr), .addr(b_addr), .wdata(b_wdata),
        .gnt(b_gnt), .rvalid(b_rvalid), .rdata(b_rdata), .mem_address(b_maddr),
        .mem_wren(b_mwren), .mem_data(b_mdata), .mem_q(b_mq)
    );

    ram_port_arbiter #(.N_CH(3), .ADDR_W(16), .DATA_W(16), .RD_LAT(3), .MODE(0)) dut_c (
        .clock(clk), .reset(rst), .req(c_req), .wr(c_wr), .addr(c_addr), .wdata(c_wdata),
        .gnt(c_gnt), .rvalid(c_rvalid), .rdata(c_rdata), .mem_address(c_maddr),
        .mem_wren(c_mwren), .mem_data(c_mdata), .mem_q(c_mq)
    );

    // Behavioural RAMs: address sampled on the edge, q valid RD_LAT-1 edges later.
    logic [15:0] mem_a [256];
    logic [15:0] a_r0, a_r1;
    always @(posedge clk) begin
        if (pl_we) mem_a[pl_addr] <= pl_data;
        else if (a_mwren) mem_a[a_maddr[7:0]] <= a_mdata;
        a_r0 <= mem_a[a_maddr[7:0]];
        a_r1 <= a_r0;
    end
    assign a_mq = a_r1;

    logic [15:0] mem_c [256];
    logic [15:0] c_r0, c_r1, c_r2;
    always @(posedge clk) begin
        if (pl_we) mem_c[pl_addr] <= pl_data;
        else if (c_mwren) mem_c[c_maddr[7:0]] <= c_mdata;
        c_r0 <= mem_c[c_maddr[7:0]];
        c_r1 <= c_r0;
        c_r2 <= c_r1;
    end
    assign c_mq = c_r2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state with every channel requesting
        a_req = 2'b11; a_wr = 2'b11; b_req = 2'b11; c_req = 3'b111;
        #1;
        chk("rst_a_gnt",    32'(a_gnt),    32'h0);
        chk("rst_a_rvalid", 32'(a_rvalid), 32'h0);
        chk("rst_a_wren",   32'(a_mwren),  32'h0);
        chk("rst_b_gnt",    32'(b_gnt),    32'h0);
        chk("rst_c_gnt",    32'(c_gnt),    32'h0);

        pl_we = 1'b1;
        pl_addr = 8'h10; pl_data = 16'hBEEF; tick();
        pl_addr = 8'h30; pl_data = 16'hA0A0; tick();
        pl_addr = 8'h31; pl_data = 16'hB1B1; tick();
        pl_addr = 8'h32; pl_data = 16'hC2C2; tick();
        pl_we = 1'b0;
        chk("rst_a_gnt_hold", 32'(a_gnt),   32'h0);
        chk("rst_a_wren_hold", 32'(a_mwren), 32'h0);

        a_req = '0; a_wr = '0; b_req = '0; c_req = '0;
        rst = 1'b0;

        // Round-robin fairness: both channels write continuously
        a_wr = 2'b11; a_addr = {16'h0081, 16'h0080}; a_wdata = {16'h5555, 16'hAAAA};
        a_req = 2'b11; cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_gnt", 32'(a_gnt), (i % 2 == 0) ? 32'h1 : 32'h2);
            cnt0 += int'(a_gnt[0]);
            cnt1 += int'(a_gnt[1]);
            tick();
        end
        a_req = '0; a_wr = '0;
        chk("rr_cnt0", 32'(cnt0), 32'd4);
        chk("rr_cnt1", 32'(cnt1), 32'd4);

        // Single read from channel 0
        a_addr = {16'h0000, 16'h0010}; a_req = 2'b01;
        #1;
        chk("rd_gnt",   32'(a_gnt),   32'h1);
        chk("rd_maddr", 32'(a_maddr), 32'h0010);
        chk("rd_wren",  32'(a_mwren), 32'h0);
        tick();
        a_req = '0;
        chk("rd_rvalid_early", 32'(a_rvalid), 32'h0);
        tick();
        chk("rd_rvalid", 32'(a_rvalid), 32'h1);
        chk("rd_rdata",  32'(a_rdata),  32'hBEEF);
        tick();
        chk("rd_rvalid_after", 32'(a_rvalid), 32'h0);

        // Channel 1 writes, channel 0 reads the same address two cycles later
        a_wr = 2'b10; a_addr = {16'h0020, 16'h0000}; a_wdata = {16'h1234, 16'h0000}; a_req = 2'b10;
        #1;
        chk("wr_gnt",   32'(a_gnt),   32'h2);
        chk("wr_wren",  32'(a_mwren), 32'h1);
        chk("wr_maddr", 32'(a_maddr), 32'h0020);
        chk("wr_mdata", 32'(a_mdata), 32'h1234);
        tick();
        a_req = '0; a_wr = '0;
        #1;
        chk("wr_idle_wren", 32'(a_mwren), 32'h0);
        chk("wr_rvalid",    32'(a_rvalid), 32'h0);
        tick();
        a_addr = {16'h0000, 16'h0020}; a_req = 2'b01;
        #1;
        chk("wrrd_gnt",  32'(a_gnt),   32'h1);
        chk("wrrd_wren", 32'(a_mwren), 32'h0);
        tick();
        a_req = '0;
        tick();
        chk("wrrd_rvalid", 32'(a_rvalid), 32'h1);
        chk("wrrd_rdata",  32'(a_rdata),  32'h1234);
        tick();

        // Reset one cycle after a channel-0 read grant (ptr is 1 at this point)
        a_addr = {16'h0000, 16'h0010}; a_req = 2'b01;
        #1;
        chk("mr_gnt", 32'(a_gnt), 32'h1);
        tick();
        a_req = 2'b11; a_wr = 2'b11; rst = 1'b1;
        #1;
        chk("mr_rst_gnt",    32'(a_gnt),    32'h0);
        chk("mr_rst_rvalid", 32'(a_rvalid), 32'h0);
        chk("mr_rst_wren",   32'(a_mwren),  32'h0);
        tick();
        chk("mr_rst_rvalid2", 32'(a_rvalid), 32'h0);
        chk("mr_rst_gnt2",    32'(a_gnt),    32'h0);
        tick();
        rst = 1'b0; a_addr = {16'h0091, 16'h0090};
        #1;
        chk("mr_post_gnt", 32'(a_gnt), 32'h1);
        tick();
        a_req = '0; a_wr = '0;
        #1;
        chk("mr_post_rvalid0", 32'(a_rvalid), 32'h0);
        tick();
        chk("mr_post_rvalid1", 32'(a_rvalid), 32'h0);

        // Fixed priority: both request for 4 cycles, then channel 0 drops
        b_req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fp_gnt0", 32'(b_gnt), 32'h1);
            tick();
        end
        b_req = 2'b10;
        #1;
        chk("fp_gnt1", 32'(b_gnt), 32'h2);
        tick();
        b_req = '0;

        // Interleaved reads on the 3-channel, latency-3 instance
        c_wr = '0; c_addr = {16'h0032, 16'h0031, 16'h0030};
        c_req = 3'b001;
        #1;
        chk("il_gnt0", 32'(c_gnt), 32'h1);
        tick();
        c_req = 3'b010;
        #1;
        chk("il_gnt1", 32'(c_gnt), 32'h2);
        tick();
        c_req = 3'b100;
        #1;
        chk("il_gnt2",       32'(c_gnt),    32'h4);
        chk("il_rvalid_pre", 32'(c_rvalid), 32'h0);
        tick();
        c_req = '0;
        chk("il_rvalid0", 32'(c_rvalid), 32'h1);
        chk("il_rdata0",  32'(c_rdata),  32'hA0A0);
        tick();
        chk("il_rvalid1", 32'(c_rvalid), 32'h2);
        chk("il_rdata1",  32'(c_rdata),  32'hB1B1);
        tick();
        chk("il_rvalid2", 32'(c_rvalid), 32'h4);
        chk("il_rdata2",  32'(c_rdata),  32'hC2C2);
        tick();
        chk("il_rvalid_end", 32'(c_rvalid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
